// File: rtl/uart_bench_agent.sv
// UART stimulus/monitor agent: serialises queued words onto SER_OUT, deserialises
// and checks frames arriving on SER_IN, and flags a line that has gone quiet.
//
// state    | meaning (shared by the TX and RX FSMs)
// S_IDLE   | line idle; TX waits for FIFO data, RX waits for a 1->0 edge
// S_START  | start bit (TX drives 0; RX checks it at mid-bit)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit, only reachable when PARITY != 0
// S_STOP   | stop bit (TX drives 1; RX checks it and pushes the frame)
module uart_bench_agent #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 TX_BUSY,
    output logic                 SER_OUT,
    input  logic                 SER_IN,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 RX_PARITY_ERR,
    output logic                 RX_FRAME_ERR,
    output logic                 RX_OVERFLOW,
    output logic                 TIMEOUT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_PRE    = WW'(TIMEOUT_CYCLES - 1);
    localparam logic          ODD       = (PARITY == 2);
    localparam bit            HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wr, tx_rd;
    logic [AW:0]          tx_count;
    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    state_t               tx_state;
    logic [CW-1:0]        tx_baud;
    logic [3:0]           tx_bits;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_ser;

    assign tx_full  = (tx_count == DEPTH_CNT);
    assign tx_empty = (tx_count == '0);
    assign tx_head  = tx_mem[tx_rd];
    assign tx_push  = TX_VALID && !tx_full;
    assign tx_pop   = !tx_empty &&
                      ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_baud == '0));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr] <= TX_DATA;
                tx_wr         <= tx_wr + AW'(1);
            end
            if (tx_pop) tx_rd <= tx_rd + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_state <= S_IDLE;
            tx_ser   <= 1'b1;
            tx_baud  <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else if (tx_state == S_IDLE) begin
            if (tx_pop) begin
                tx_state <= S_START;
                tx_ser   <= 1'b0;
                tx_baud  <= BIT_LAST;
                tx_shift <= tx_head;
                tx_par   <= (^tx_head) ^ ODD;
            end
        end else if (tx_baud != '0) begin
            tx_baud <= tx_baud - 1'b1;
        end else begin
            tx_baud <= BIT_LAST;
            case (tx_state)
                S_START: begin
                    tx_state <= S_DATA;
                    tx_ser   <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_bits  <= DATA_LAST;
                end
                S_DATA: begin
                    if (tx_bits != '0) begin
                        tx_ser   <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bits  <= tx_bits - 1'b1;
                    end else if (HAS_PAR) begin
                        tx_state <= S_PARITY;
                        tx_ser   <= tx_par;
                    end else begin
                        tx_state <= S_STOP;
                        tx_ser   <= 1'b1;
                    end
                end
                S_PARITY: begin
                    tx_state <= S_STOP;
                    tx_ser   <= 1'b1;
                end
                S_STOP: begin
                    // Queued data follows the stop bit with no idle gap.
                    if (tx_pop) begin
                        tx_state <= S_START;
                        tx_ser   <= 1'b0;
                        tx_shift <= tx_head;
                        tx_par   <= (^tx_head) ^ ODD;
                    end else begin
                        tx_state <= S_IDLE;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic                 rx_s1, rx_s2, rx_prev;
    state_t               rx_state;
    logic [CW-1:0]        rx_baud;
    logic [3:0]           rx_bits;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;
    logic                 rx_parity_err, rx_frame_err, rx_overflow;

    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wr, rx_rd;
    logic [AW:0]          rx_count;
    logic                 rx_full, rx_empty, rx_pop, rx_req, rx_push, rx_drop;

    assign rx_full  = (rx_count == DEPTH_CNT);
    assign rx_empty = (rx_count == '0);
    assign rx_pop   = !rx_empty && RX_READY;
    assign rx_req   = (rx_state == S_STOP) && (rx_baud == '0) && rx_s2;
    assign rx_push  = rx_req && (!rx_full || rx_pop);
    assign rx_drop  = rx_req && rx_full && !rx_pop;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= S_IDLE;
            rx_baud       <= '0;
            rx_bits       <= '0;
            rx_shift      <= '0;
            rx_par        <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overflow   <= 1'b0;
        end else begin
            rx_s1   <= SER_IN;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_state == S_IDLE) begin
                if (!rx_s2 && rx_prev) begin
                    rx_state <= S_START;
                    rx_baud  <= HALF_LAST;
                end
            end else if (rx_baud != '0) begin
                rx_baud <= rx_baud - 1'b1;
            end else begin
                rx_baud <= BIT_LAST;
                case (rx_state)
                    S_START: begin
                        // A line that is high again at mid-bit was a glitch.
                        if (rx_s2) rx_state <= S_IDLE;
                        else begin
                            rx_state <= S_DATA;
                            rx_bits  <= DATA_LAST;
                            rx_par   <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        rx_par   <= rx_par ^ rx_s2;
                        if (rx_bits == '0) rx_state <= HAS_PAR ? S_PARITY : S_STOP;
                        else               rx_bits  <= rx_bits - 1'b1;
                    end
                    S_PARITY: begin
                        if (rx_s2 != (rx_par ^ ODD)) rx_parity_err <= 1'b1;
                        rx_state <= S_STOP;
                    end
                    S_STOP: begin
                        rx_state <= S_IDLE;
                        if (!rx_s2)  rx_frame_err <= 1'b1;
                        if (rx_drop) rx_overflow  <= 1'b1;
                    end
                    default: rx_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr] <= rx_shift;
                rx_wr         <= rx_wr + AW'(1);
            end
            if (rx_pop) rx_rd <= rx_rd + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- idle watchdog ----------------
    logic [WW-1:0] wd_count;
    logic          wd_clear;
    logic          timeout_q;

    assign wd_clear = tx_pop || rx_req;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wd_count  <= '0;
            timeout_q <= 1'b0;
        end else if (wd_clear) begin
            wd_count <= '0;
        end else if (wd_count != WD_MAX) begin
            wd_count <= wd_count + 1'b1;
            if (wd_count == WD_PRE) timeout_q <= 1'b1;
        end
    end

    assign TX_READY      = !tx_full;
    assign TX_BUSY       = (tx_state != S_IDLE) || !tx_empty;
    assign SER_OUT       = tx_ser;
    assign RX_DATA       = rx_mem[rx_rd];
    assign RX_VALID      = !rx_empty;
    assign RX_PARITY_ERR = rx_parity_err;
    assign RX_FRAME_ERR  = rx_frame_err;
    assign RX_OVERFLOW   = rx_overflow;
    assign TIMEOUT       = timeout_q;

endmodule

// File: tb/tb_uart_bench_agent.sv
// Directed bench for uart_bench_agent: instance a (no parity, short watchdog)
// covers TX timing, loopback, glitch, overflow, timeout and reset; instance b covers parity.
module tb_uart_bench_agent;

    logic       clk, reset;
    logic [7:0] tx_data_a, rx_data_a, tx_data_b, rx_data_b;
    logic       tx_valid_a, tx_ready_a, tx_busy_a, ser_out_a, ser_in_a, rx_valid_a, rx_ready_a;
    logic       rx_parity_err_a, rx_frame_err_a, rx_overflow_a, timeout_a;
    logic       tx_valid_b, tx_ready_b, tx_busy_b, ser_out_b, ser_in_b, rx_valid_b, rx_ready_b;
    logic       rx_parity_err_b, rx_frame_err_b, rx_overflow_b, timeout_b;
    logic       a_loop, a_drive, b_inv, b_force_low;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int k, r0;

    assign ser_in_a = a_loop ? ser_out_a : a_drive;
    assign ser_in_b = b_force_low ? 1'b0 : (ser_out_b ^ b_inv);

    uart_bench_agent #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0),
                       .FIFO_DEPTH(4), .TIMEOUT_CYCLES(1000)) u_dut_a (
        .CLK(clk), .RESET(reset),
        .TX_DATA(tx_data_a), .TX_VALID(tx_valid_a), .TX_READY(tx_ready_a), .TX_BUSY(tx_busy_a),
        .SER_OUT(ser_out_a), .SER_IN(ser_in_a),
        .RX_DATA(rx_data_a), .RX_VALID(rx_valid_a), .RX_READY(rx_ready_a),
        .RX_PARITY_ERR(rx_parity_err_a), .RX_FRAME_ERR(rx_frame_err_a),
        .RX_OVERFLOW(rx_overflow_a), .TIMEOUT(timeout_a)
    );

    uart_bench_agent #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1),
                       .FIFO_DEPTH(4)) u_dut_b (
        .CLK(clk), .RESET(reset),
        .TX_DATA(tx_data_b), .TX_VALID(tx_valid_b), .TX_READY(tx_ready_b), .TX_BUSY(tx_busy_b),
        .SER_OUT(ser_out_b), .SER_IN(ser_in_b),
        .RX_DATA(rx_data_b), .RX_VALID(rx_valid_b), .RX_READY(rx_ready_b),
        .RX_PARITY_ERR(rx_parity_err_b), .RX_FRAME_ERR(rx_frame_err_b),
        .RX_OVERFLOW(rx_overflow_b), .TIMEOUT(timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d required=finish", cyc);
        $fatal(1, "bench did not finish");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        int n = 0;
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        while (!tx_ready_a && n < 400) begin tick; n++; end
        chk("tx_ready_wait", tx_ready_a, 1);
        tick;
        tx_valid_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int limit);
        int n = 0;
        while (tx_busy_a && n < limit) begin tick; n++; end
        chk("tx_idle_wait", tx_busy_a, 0);
    endtask

    task automatic pop_a(input logic [7:0] exp);
        chk("rx_a_valid", rx_valid_a, 1);
        chk("rx_a_data", rx_data_a, exp);
        rx_ready_a = 1'b1;
        tick;
        rx_ready_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d, output int kk);
        tx_data_b  = d;
        tx_valid_b = 1'b1;
        tick;
        kk = cyc;
        tx_valid_b = 1'b0;
    endtask

    // Pushes n words on consecutive edges and checks every SER_OUT cycle
    // against the expected 10-bit frames laid end to end.
    task automatic tx_stream(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input int n);
        logic [7:0] d [3];
        int f, bi;
        logic e;
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int i = 0; i < n; i++) begin
            tx_data_a  = d[i];
            tx_valid_a = 1'b1;
            tick;
            if (i == 0) chk("tx_no_early_start", ser_out_a, 1);
        end
        tx_valid_a = 1'b0;
        for (int t = n - 1; t <= 160 * n; t++) begin
            if (t >= 1) begin
                f  = (t - 1) / 160;
                bi = ((t - 1) % 160) / 16;
                if (bi == 0)      e = 1'b0;
                else if (bi == 9) e = 1'b1;
                else              e = d[f][bi-1];
                chk("tx_ser_bit", ser_out_a, e);
                chk("tx_busy_high", tx_busy_a, 1);
            end
            tick;
        end
        chk("tx_busy_fall", tx_busy_a, 0);
        chk("tx_line_idle", ser_out_a, 1);
    endtask

    initial begin
        reset = 1'b1;
        tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b0;
        tx_data_b = '0; tx_valid_b = 1'b0; rx_ready_b = 1'b0;
        a_loop = 1'b1; a_drive = 1'b1; b_inv = 1'b0; b_force_low = 1'b0;
        repeat (3) tick;

        chk("rst_ser_out", ser_out_a, 1);
        chk("rst_tx_ready", tx_ready_a, 1);
        chk("rst_tx_busy", tx_busy_a, 0);
        chk("rst_rx_valid", rx_valid_a, 0);
        chk("rst_rx_data", rx_data_a, 0);
        chk("rst_flags", {rx_parity_err_a, rx_frame_err_a, rx_overflow_a, timeout_a}, 0);
        chk("rst_ser_out_b", ser_out_b, 1);

        r0 = cyc;
        reset = 1'b0;
        wait_until(r0 + 999);
        chk("timeout_before", timeout_a, 0);
        tick;
        chk("timeout_at_1000", timeout_a, 1);
        chk("timeout_b_quiet", timeout_b, 0);

        tx_stream(8'hA5, 8'h00, 8'h00, 1);
        pop_a(8'hA5);
        chk("rx_a_empty_1", rx_valid_a, 0);

        tx_stream(8'h00, 8'hFF, 8'h3C, 3);
        pop_a(8'h00);
        pop_a(8'hFF);
        pop_a(8'h3C);
        chk("rx_a_empty_2", rx_valid_a, 0);
        chk("b2b_no_flags", {rx_parity_err_a, rx_frame_err_a, rx_overflow_a}, 0);

        a_loop = 1'b0;
        repeat (5) tick;
        a_drive = 1'b0;
        repeat (3) tick;
        a_drive = 1'b1;
        repeat (40) tick;
        chk("glitch_no_push", rx_valid_a, 0);
        chk("glitch_no_flags", {rx_parity_err_a, rx_frame_err_a, rx_overflow_a}, 0);
        a_loop = 1'b1;

        push_a(8'h11);
        push_a(8'h22);
        push_a(8'h33);
        push_a(8'h44);
        push_a(8'h55);
        wait_idle_a(1200);
        repeat (10) tick;
        chk("overflow_set", rx_overflow_a, 1);
        pop_a(8'h11);
        pop_a(8'h22);
        pop_a(8'h33);
        pop_a(8'h44);
        chk("overflow_fifth_dropped", rx_valid_a, 0);

        push_b(8'h07, k);
        wait_until(k + 150);
        chk("b_parity_bit_even", ser_out_b, 1);
        wait_until(k + 180);
        chk("b_good_valid", rx_valid_b, 1);
        chk("b_good_data", rx_data_b, 8'h07);
        chk("b_good_flags", {rx_parity_err_b, rx_frame_err_b}, 0);
        rx_ready_b = 1'b1; tick; rx_ready_b = 1'b0;
        chk("b_empty_1", rx_valid_b, 0);

        push_b(8'h55, k);
        wait_until(k + 161);
        b_force_low = 1'b1;
        wait_until(k + 180);
        b_force_low = 1'b0;
        repeat (5) tick;
        chk("b_frame_err", rx_frame_err_b, 1);
        chk("b_frame_no_push", rx_valid_b, 0);
        chk("b_frame_no_parity", rx_parity_err_b, 0);

        push_b(8'h07, k);
        wait_until(k + 145);
        b_inv = 1'b1;
        wait_until(k + 161);
        b_inv = 1'b0;
        wait_until(k + 180);
        chk("b_parity_err", rx_parity_err_b, 1);
        chk("b_parity_valid", rx_valid_b, 1);
        chk("b_parity_data", rx_data_b, 8'h07);
        rx_ready_b = 1'b1; tick; rx_ready_b = 1'b0;
        chk("b_empty_2", rx_valid_b, 0);

        push_a(8'h00);
        repeat (50) tick;
        chk("mid_frame_low", ser_out_a, 0);
        chk("mid_frame_busy", tx_busy_a, 1);
        chk("mid_sticky", {rx_overflow_a, timeout_a}, 2'b11);
        reset = 1'b1;
        tick;
        chk("abort_ser_out", ser_out_a, 1);
        chk("abort_tx_busy", tx_busy_a, 0);
        chk("abort_tx_ready", tx_ready_a, 1);
        chk("abort_rx_valid", rx_valid_a, 0);
        chk("abort_flags_a", {rx_parity_err_a, rx_frame_err_a, rx_overflow_a, timeout_a}, 0);
        chk("abort_flags_b", {rx_parity_err_b, rx_frame_err_b}, 0);
        reset = 1'b0;
        repeat (20) tick;
        chk("post_reset_idle", ser_out_a, 1);
        chk("post_reset_not_busy", tx_busy_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
